// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and helpers for the SECDED codec family.
//   ecc_err_e       : decoder result class (NONE / CORR / UNCORR)
//   calc_r          : number of Hamming check bits for a payload width
//   is_pow2         : true for Hamming check-bit positions
//   pos_to_data_idx : Hamming position -> payload bit index
//   ecc_encode      : reference/encoder function, codeword in the low CODE_W bits
package ecc_pkg;

   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned MAX_CODE_W = 72;

   typedef enum logic [1:0] {
      ECC_NONE   = 2'b00,
      ECC_CORR   = 2'b01,
      ECC_UNCORR = 2'b10
   } ecc_err_e;

   // Smallest r with 2^r >= data_w + r + 1.
   function automatic int unsigned calc_r(input int unsigned data_w);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < (data_w + r + 1)) r = r + 1;
      return r;
   endfunction

   function automatic logic is_pow2(input int unsigned x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   // Data bits fill non-power-of-two positions in ascending order, so the
   // index is the position minus the check positions at or below it, minus one.
   function automatic int unsigned pos_to_data_idx(input int unsigned pos);
      int unsigned n;
      n = 0;
      for (int unsigned k = 1; k <= pos; k = k << 1) n = n + 1;
      return pos - n - 1;
   endfunction

   // Bit 0 is overall parity; bits 1..data_w+r follow Hamming positions.
   function automatic logic [MAX_CODE_W-1:0] ecc_encode(input logic [MAX_DATA_W-1:0] data,
                                                        input int unsigned data_w = 32);
      logic [MAX_CODE_W-1:0] code;
      int unsigned           r;
      int unsigned           n;
      logic                  p;
      code = '0;
      r    = calc_r(data_w);
      n    = data_w + r;
      for (int unsigned pos = 1; pos <= n; pos++) begin
         if (!is_pow2(pos)) code[7'(pos)] = data[6'(pos_to_data_idx(pos))];
      end
      // Check bit i covers every position with bit i set; it is still zero here.
      for (int unsigned i = 0; i < r; i++) begin
         p = 1'b0;
         for (int unsigned pos = 1; pos <= n; pos++) begin
            if (((pos >> i) & 32'd1) != 0) p = p ^ code[7'(pos)];
         end
         code[7'(32'd1 << i)] = p;
      end
      code[0] = ^code;
      return code;
   endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: combinational Hamming syndrome and overall parity.
//   code       : received codeword (CODE_W)
//   syndrome_c : Hamming syndrome (R_W), zero for a clean word
//   parity_c   : XOR of all CODE_W bits, zero for a clean word
module ecc_syndrome_calc
   import ecc_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned R_W    = calc_r(DATA_W),
   parameter int unsigned CODE_W = DATA_W + R_W + 1
) (
   input  logic [CODE_W-1:0] code,
   output logic [R_W-1:0]    syndrome_c,
   output logic              parity_c
);

   localparam int unsigned IDX_W = $clog2(CODE_W);

   // Positions covered by syndrome bit b (bit 0 is never covered).
   function automatic logic [CODE_W-1:0] chk_mask(input int unsigned b);
      logic [CODE_W-1:0] m;
      m = '0;
      for (int unsigned pos = 1; pos < CODE_W; pos++) begin
         if (((pos >> b) & 32'd1) != 0) m[IDX_W'(pos)] = 1'b1;
      end
      return m;
   endfunction

   for (genvar i = 0; i < R_W; i++) begin : g_syn
      localparam logic [CODE_W-1:0] MASK = chk_mask(i);
      assign syndrome_c[i] = ^(code & MASK);
   end

   assign parity_c = ^code;

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// ecc_secded_dec_pipe: 2-stage pipelined SECDED decoder with valid/ready
// streaming, saturating error counters and a first-fault log.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/in_code     : codeword input stream
//   out_valid/out_ready           : result stream handshake
//   out_data/out_err/out_syndrome : corrected payload, class, {parity, syndrome}
//   clr_cnt                       : pulse, clears counters and fault log
//   cnt_corr/cnt_uncorr           : saturating counts of CORR / UNCORR transfers
//   log_valid/log_syndrome        : first UNCORR syndrome since reset/clear
// Optional macro ECC_ERR_INJECT_EN adds inj_en/inj_mask to XOR an error
// pattern into each accepted codeword.
module ecc_secded_dec_pipe
   import ecc_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned R_W    = calc_r(DATA_W),
   parameter int unsigned CODE_W = DATA_W + R_W + 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
`ifdef ECC_ERR_INJECT_EN
   input  logic              inj_en,
   input  logic [CODE_W-1:0] inj_mask,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output ecc_err_e          out_err,
   output logic [R_W:0]      out_syndrome,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_uncorr,
   output logic              log_valid,
   output logic [R_W:0]      log_syndrome
);

   localparam int unsigned      N_POS   = DATA_W + R_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              en1;
   logic              en2;
   logic              xfer;
   logic [CODE_W-1:0] code_in;
   logic [R_W-1:0]    syn_c;
   logic              par_c;
   logic [DATA_W-1:0] data_c;
   logic [DATA_W-1:0] flip_c;
   ecc_err_e          err_c;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [R_W-1:0]    s1_syn;
   logic              s1_par;

   // Pipeline enables; in_ready is combinational from out_ready by design.
   assign en2      = !out_valid || out_ready;
   assign en1      = !s1_valid || en2;
   assign in_ready = en1;
   assign xfer     = out_valid && out_ready;

`ifdef ECC_ERR_INJECT_EN
   assign code_in = in_code ^ (inj_en ? inj_mask : '0);
`else
   assign code_in = in_code;
`endif

   ecc_syndrome_calc #(
      .DATA_W (DATA_W),
      .R_W    (R_W),
      .CODE_W (CODE_W)
   ) u_syndrome_calc (
      .code       (code_in),
      .syndrome_c (syn_c),
      .parity_c   (par_c)
   );

   // Payload extraction (stage 1) and single-bit correction mask (stage 2).
   for (genvar pos = 1; pos <= N_POS; pos++) begin : g_map
      if (!is_pow2(pos)) begin : g_data
         localparam int unsigned IDX = pos_to_data_idx(pos);
         assign data_c[IDX] = code_in[pos];
         assign flip_c[IDX] = s1_par && (s1_syn == R_W'(pos));
      end
   end

   // Classification; syndromes past the last position cannot be a single error.
   always_comb begin
      err_c = ECC_NONE;
      if (s1_par) begin
         err_c = (s1_syn > R_W'(N_POS)) ? ECC_UNCORR : ECC_CORR;
      end else if (s1_syn != '0) begin
         err_c = ECC_UNCORR;
      end
   end

   // Stage 1: payload, syndrome and parity of the accepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (en1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= data_c;
            s1_syn  <= syn_c;
            s1_par  <= par_c;
         end
      end
   end

   // Stage 2: corrected result; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_err      <= ECC_NONE;
         out_syndrome <= '0;
      end else if (en2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data     <= s1_data ^ flip_c;
            out_err      <= err_c;
            out_syndrome <= {s1_par, s1_syn};
         end
      end
   end

   // Counters and first-fault log, updated on output transfers; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_corr     <= '0;
         cnt_uncorr   <= '0;
         log_valid    <= 1'b0;
         log_syndrome <= '0;
      end else if (clr_cnt) begin
         cnt_corr     <= '0;
         cnt_uncorr   <= '0;
         log_valid    <= 1'b0;
         log_syndrome <= '0;
      end else if (xfer) begin
         if ((out_err == ECC_CORR) && (cnt_corr != CNT_MAX)) begin
            cnt_corr <= cnt_corr + CNT_W'(1);
         end
         if (out_err == ECC_UNCORR) begin
            if (cnt_uncorr != CNT_MAX) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            if (!log_valid) begin
               log_valid    <= 1'b1;
               log_syndrome <= out_syndrome;
            end
         end
      end
   end

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// tb_ecc_secded_dec_pipe: self-checking bench for ecc_secded_dec_pipe
// (DATA_W=32, CODE_W=39, CNT_W=2 so saturation is reachable).
module tb_ecc_secded_dec_pipe;
   import ecc_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned R_W    = 6;
   localparam int unsigned CODE_W = 39;
   localparam int unsigned CNT_W  = 2;
   localparam int          CNT_SAT = 3;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   ecc_err_e          out_err;
   logic [R_W:0]      out_syndrome;
   logic              clr_cnt;
   logic [CNT_W-1:0]  cnt_corr;
   logic [CNT_W-1:0]  cnt_uncorr;
   logic              log_valid;
   logic [R_W:0]      log_syndrome;
`ifdef ECC_ERR_INJECT_EN
   logic              inj_en   = 1'b0;
   logic [CODE_W-1:0] inj_mask = '0;
`endif

   ecc_secded_dec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
`ifdef ECC_ERR_INJECT_EN
      .inj_en       (inj_en),
      .inj_mask     (inj_mask),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_err      (out_err),
      .out_syndrome (out_syndrome),
      .clr_cnt      (clr_cnt),
      .cnt_corr     (cnt_corr),
      .cnt_uncorr   (cnt_uncorr),
      .log_valid    (log_valid),
      .log_syndrome (log_syndrome)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [38:0] flip;
      logic [31:0] exp_data;
      ecc_err_e    exp_err;
      logic [6:0]  exp_syn;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      ecc_err_e    err;
      logic [6:0]  syn;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[11];
   int   errors = 0;
   int   checks = 0;

   // Counter / log model, advanced from expected results of each transfer.
   int         m_corr   = 0;
   int         m_uncorr = 0;
   logic       m_log_v  = 1'b0;
   logic [6:0] m_log_syn = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [38:0] enc(input logic [31:0] d);
      return 39'(ecc_encode(64'(d), 32));
   endfunction

   function automatic exp_t mk(input logic [31:0] d, input ecc_err_e e, input logic [6:0] s);
      exp_t r;
      r.data = d;
      r.err  = e;
      r.syn  = s;
      return r;
   endfunction

   // Present a word and hold it until a handshake cycle; push its expectation.
   task automatic send(input logic [31:0] d, input logic [38:0] flip, input exp_t e);
      logic acc;
      int   n;
      acc      = 1'b0;
      n        = 0;
      in_code  = enc(d) ^ flip;
      in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
      end else begin
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: scoreboard compare plus continuous counter/log check.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_corr    = 0;
         m_uncorr  = 0;
         m_log_v   = 1'b0;
         m_log_syn = '0;
      end else begin
         chk("cnt_corr", 64'(cnt_corr), 64'(m_corr));
         chk("cnt_uncorr", 64'(cnt_uncorr), 64'(m_uncorr));
         chk("log_valid", 64'(log_valid), 64'(m_log_v));
         chk("log_syndrome", 64'(log_syndrome), 64'(m_log_syn));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: data %0h with empty scoreboard", out_data);
            end else begin
               mon_e = sb.pop_front();
               chk("out_data", 64'(out_data), 64'(mon_e.data));
               chk("out_err", 64'(out_err), 64'(mon_e.err));
               chk("out_syndrome", 64'(out_syndrome), 64'(mon_e.syn));
               if (mon_e.err == ECC_CORR && m_corr < CNT_SAT) m_corr++;
               if (mon_e.err == ECC_UNCORR) begin
                  if (m_uncorr < CNT_SAT) m_uncorr++;
                  if (!m_log_v) begin
                     m_log_v   = 1'b1;
                     m_log_syn = mon_e.syn;
                  end
               end
            end
         end
         if (clr_cnt) begin
            m_corr    = 0;
            m_uncorr  = 0;
            m_log_v   = 1'b0;
            m_log_syn = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = '{32'hDEADBEEF, 39'h0,                               32'hDEADBEEF, ECC_NONE,   7'h00};
      vecs[1]  = '{32'hDEADBEEF, 39'd1 << 3,                          32'hDEADBEEF, ECC_CORR,   7'h43};
      vecs[2]  = '{32'hDEADBEEF, (39'd1 << 3) | (39'd1 << 5),         32'hDEADBEEC, ECC_UNCORR, 7'h06};
      vecs[3]  = '{32'hDEADBEEF, 39'd1,                               32'hDEADBEEF, ECC_CORR,   7'h40};
      vecs[4]  = '{32'h12345678, 39'd1 << 1,                          32'h12345678, ECC_CORR,   7'h41};
      vecs[5]  = '{32'h12345678, 39'd1 << 38,                         32'h12345678, ECC_CORR,   7'h66};
      vecs[6]  = '{32'hA5A5A5A5, 39'd1 << 32,                         32'hA5A5A5A5, ECC_CORR,   7'h60};
      vecs[7]  = '{32'h00000000, (39'd1 << 37) | (39'd1 << 38),       32'hC0000000, ECC_UNCORR, 7'h03};
      vecs[8]  = '{32'hFFFFFFFF, (39'd1 << 1) | (39'd1 << 2) | (39'd1 << 4), 32'hFFFFFFF7, ECC_CORR, 7'h47};
      vecs[9]  = '{32'h00000000, 39'd1 | (39'd1 << 7) | (39'd1 << 32), 32'h00000008, ECC_UNCORR, 7'h67};
      vecs[10] = '{32'h55AA55AA, 39'd1 | (39'd1 << 2),                32'h55AA55AA, ECC_UNCORR, 7'h02};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = '0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;

      // Reset values.
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'(ECC_NONE));
      chk("rst_out_syndrome", 64'(out_syndrome), 64'd0);
      chk("rst_cnt_corr", 64'(cnt_corr), 64'd0);
      chk("rst_cnt_uncorr", 64'(cnt_uncorr), 64'd0);
      chk("rst_log", 64'({log_valid, log_syndrome}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Clean word latency: out_valid exactly two cycles after the handshake cycle.
      @(posedge clk);
      #1;
      in_code  = enc(32'hDEADBEEF);
      in_valid = 1'b1;
      @(negedge clk);
      chk("lat_handshake", 64'(in_ready), 64'd1);
      sb.push_back(mk(32'hDEADBEEF, ECC_NONE, 7'h00));
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
      drain();

      // Table vectors, back to back.
      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++) begin
         send(vecs[i].data, vecs[i].flip, mk(vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_syn));
      end
      in_valid = 1'b0;
      drain();
      chk("tbl_cnt_corr_sat", 64'(cnt_corr), 64'd3);
      chk("tbl_cnt_uncorr_sat", 64'(cnt_uncorr), 64'd3);
      chk("tbl_log_valid", 64'(log_valid), 64'd1);
      chk("tbl_log_first", 64'(log_syndrome), 64'h06);

      // Backpressure: two words fill the pipe, then in_ready drops and outputs hold.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'h11111111, 39'h0, mk(32'h11111111, ECC_NONE, 7'h00));
      send(32'h22222222, 39'd1 << 6, mk(32'h22222222, ECC_CORR, 7'h46));
      in_code  = enc(32'h33333333) ^ ((39'd1 << 6) | (39'd1 << 7));
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_out_data", 64'(out_data), 64'h11111111);
         chk("stall_out_syn", 64'(out_syndrome), 64'h00);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(32'h33333333, (39'd1 << 6) | (39'd1 << 7), mk(32'h3333333F, ECC_UNCORR, 7'h01));
      send(32'h44444444, 39'h0, mk(32'h44444444, ECC_NONE, 7'h00));
      in_valid = 1'b0;
      drain();

      // Saturation with CNT_W=2, then clear coinciding with an UNCORR transfer.
      @(posedge clk);
      #1 clr_cnt = 1'b1;
      @(posedge clk);
      #1 clr_cnt = 1'b0;
      @(negedge clk);
      chk("clr_cnt_corr", 64'(cnt_corr), 64'd0);
      chk("clr_log_valid", 64'(log_valid), 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         send(32'hDEADBEEF ^ 32'(i), 39'd1 << (9 + i),
              mk(32'hDEADBEEF ^ 32'(i), ECC_CORR, 7'(7'h40 | 7'(9 + i))));
      end
      in_valid = 1'b0;
      drain();
      chk("sat_cnt_corr", 64'(cnt_corr), 64'd3);
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'h13579BDF, (39'd1 << 3) | (39'd1 << 5), mk(32'h13579BDC, ECC_UNCORR, 7'h06));
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("clr_wait_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      clr_cnt   = 1'b1;
      @(posedge clk);
      #1 clr_cnt = 1'b0;
      @(negedge clk);
      chk("clrwin_cnt_corr", 64'(cnt_corr), 64'd0);
      chk("clrwin_cnt_uncorr", 64'(cnt_uncorr), 64'd0);
      chk("clrwin_log_valid", 64'(log_valid), 64'd0);
      chk("clrwin_log_syn", 64'(log_syndrome), 64'd0);

      // Reset with two words in flight.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'hCAFEF00D, 39'd1 << 3, mk(32'hCAFEF00D, ECC_CORR, 7'h43));
      send(32'h0000FFFF, (39'd1 << 3) | (39'd1 << 5), mk(32'h0000FFFC, ECC_UNCORR, 7'h06));
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_counters", 64'({cnt_corr, cnt_uncorr, log_valid}), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("postrst_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      send(32'h0BADF00D, 39'h0, mk(32'h0BADF00D, ECC_NONE, 7'h00));
      in_valid = 1'b0;
      drain();
      chk("postrst_cnt_corr", 64'(cnt_corr), 64'd0);
      chk("postrst_cnt_uncorr", 64'(cnt_uncorr), 64'd0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ecc_secded_dec_pipe.md
# ecc_secded_dec_pipe

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) decoder for streamed codewords. It is the successor to the fixed 8-bit Hamming encoder/decoder pair. It adds configurable data width, an overall-parity bit for double-error detection, a valid/ready stream interface with a 2-stage pipeline, saturating error counters and a first-fault log. It sits on read-return paths, between memory or link and consumer logic.

## Interface
- `DATA_W`, default 32: payload width, range 4..64.
- `R_W`, default `ecc_pkg::calc_r(DATA_W)`: Hamming check bits, the smallest r with 2^r ≥ DATA_W+r+1. It is derived and must not be overridden.
- `CODE_W`, default DATA_W+R_W+1: codeword width.
- `CNT_W`, default 16: width of each error counter.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: codeword valid.
- `in_ready`, out, 1: stage 1 can accept.
- `in_code`, in, CODE_W: received codeword.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts.
- `out_data`, out, DATA_W: corrected payload.
- `out_err`, out, 2: result class, `ecc_err_e`. Encodings: 00 NONE, 01 CORR, 10 UNCORR.
- `out_syndrome`, out, R_W+1: {overall parity, Hamming syndrome}.
- `clr_cnt`, in, 1: single-cycle pulse; clears the counters and the fault log.
- `cnt_corr`, out, CNT_W: count of corrected words.
- `cnt_uncorr`, out, CNT_W: count of uncorrectable words.
- `log_valid`, out, 1: sticky flag; an uncorrectable word has been logged.
- `log_syndrome`, out, R_W+1: syndrome of the first uncorrectable word.

## Operation
Codeword layout:
- Bit 0 holds the overall parity, the XOR of all other code bits.
- Bits 1..DATA_W+R_W follow Hamming positions. Check bits sit at power-of-two positions. Data bits fill the remaining positions in ascending order, with data[0] at the lowest.

Stage 1 computes the Hamming syndrome `s` (R_W bits) and `p`, the XOR of all CODE_W bits. Both are registered together with the codeword.

Stage 2 classifies the word and corrects it:
- s==0, p==0: NONE. Data passes through.
- p==1, s==0: CORR. The error is in bit 0; data is unchanged.
- p==1, s is a check-bit position: CORR. Data is unchanged.
- p==1, s is a data position ≤ DATA_W+R_W: CORR. The mapped data bit is flipped.
- p==1, s > DATA_W+R_W: UNCORR. Data passes through uncorrected.
- s!=0, p==0: UNCORR (double error). Data passes through uncorrected.

Counters:
- Counters update on the output transfer (out_valid && out_ready) only.
- A CORR result increments `cnt_corr`; an UNCORR result increments `cnt_uncorr`.
- Both counters saturate at 2^CNT_W−1.

Fault log:
- On the first UNCORR transfer while log_valid==0, capture `out_syndrome` and set `log_valid`.
- Later UNCORR transfers do not overwrite the log.

Clear behaviour:
- `clr_cnt` zeroes both counters, `log_valid` and `log_syndrome` on the next edge.
- If `clr_cnt` coincides with a transfer that would update a counter or the log, the clear wins.

## Timing
- Latency: 2 cycles from an in_valid&&in_ready edge to out_valid, given no stall.
- Throughput: 1 word per cycle.
- Stage enables: en2 = !out_valid || out_ready; en1 = !s1_valid || en2; in_ready = en1. This is a combinational path from out_ready to in_ready, which is accepted.
- Stall: when out_ready=0 with both stages full, in_ready=0. All stage registers and outputs hold stable. in_code is not sampled.
- Producers must hold in_code/in_valid until in_ready is seen. Once out_valid is asserted, it stays asserted until the transfer completes.
- Reset values:
  - out_valid 0, out_data 0, out_err NONE, out_syndrome 0.
  - cnt_corr 0, cnt_uncorr 0, log_valid 0, log_syndrome 0.
  - Internal s1_valid 0.
  - in_ready is 1 during and after reset.
- Reset asserted mid-operation drops all in-flight words without producing output, and does not update any counter.

## Configuration
- `ECC_ERR_INJECT_EN` defined:
  - Adds input ports `inj_en` (1 bit) and `inj_mask` (CODE_W bits).
  - On acceptance, stage 1 registers in_code ^ (inj_en ? inj_mask : 0).
  - out_syndrome, the counters and the log all reflect the injected word.
- `ECC_ERR_INJECT_EN` undefined: the ports are absent and no XOR logic is present.

## Structure
- Package `ecc_pkg` contains:
  - enum `ecc_err_e`;
  - function `calc_r(data_w)`;
  - function `ecc_encode(data)`, which returns the codeword and is used by the bench and by encoder blocks;
  - function `is_pow2`;
  - function `pos_to_data_idx`, which maps a Hamming position to a data index.
- One sub-module, `ecc_syndrome_calc`, is natural. It is combinational: CODE_W codeword in, R_W syndrome plus overall parity out, instantiated in stage 1.

## Test plan
All scenarios use DATA_W=32, so CODE_W=39.
1. Clean word: encode 32'hDEADBEEF and send it with out_ready=1. Expect out_data=DEADBEEF, out_err=NONE, syndrome 0, out_valid exactly 2 cycles after acceptance.
2. Single data-bit error: flip the code bit holding data[0] (position 3, i.e. code bit 3). Expect out_data=DEADBEEF, out_err=CORR, out_syndrome={1,6'd3}, cnt_corr=1.
3. Double error: flip code bits 3 and 5. Expect out_err=UNCORR, out_data=DEADBEEF^32'h3 (uncorrected), cnt_uncorr=1, log_valid=1, log_syndrome={0,6'd6}.
4. Backpressure: send 4 back-to-back words with out_ready=0 for 5 cycles, then 1. Expect in_ready=0 after 2 words, no loss, in-order outputs, outputs stable during the stall.
5. Counter behaviour: with CNT_W=2, send 5 CORR words; expect cnt_corr=3 (saturated). Then pulse clr_cnt in the same cycle as an UNCORR transfer; expect all counters 0 and log_valid=0.
6. Reset mid-flight: assert rst_n=0 with 2 words in the pipeline. Expect out_valid=0 immediately (asynchronously), no counter change, and a clean word accepted normally after release.
